// File: rtl/ltssm_pkg.sv
// Shared LTSSM definitions: ordered-set symbols, TS symbol positions and rx FSM states.
// Used by both the TS generator and the TS receiver.
package ltssm_pkg;

  localparam logic [7:0] COM    = 8'hBC;
  localparam logic [7:0] PADG12 = 8'hF7;
  localparam logic [7:0] TS1_ID = 8'h4A;
  localparam logic [7:0] TS2_ID = 8'h45;

  localparam logic [3:0] SYM_LINK = 4'd1;
  localparam logic [3:0] SYM_LANE = 4'd2;
  localparam logic [3:0] SYM_NFTS = 4'd3;
  localparam logic [3:0] SYM_RATE = 4'd4;
  localparam logic [3:0] SYM_CTRL = 4'd5;
  localparam logic [3:0] SYM_ID0  = 4'd6;
  localparam logic [3:0] SYM_LAST = 4'd15;

  typedef enum logic {
    RX_HUNT,
    RX_COLLECT
  } rx_state_t;

endpackage

// File: rtl/ts_rx.sv
// Single-lane TS1/TS2 receiver: aligns on COM, validates 16-symbol ordered sets,
// presents parsed fields and counts consecutive identical sets.
module ts_rx
  import ltssm_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sym_vld,
  input  logic [7:0]       sym,
  input  logic             sym_k,
  output logic             ts_vld,
  output logic             ts_is_ts2,
  output logic [7:0]       ts_link,
  output logic             ts_link_pad,
  output logic [7:0]       ts_lane,
  output logic             ts_lane_pad,
  output logic [7:0]       ts_nfts,
  output logic [7:0]       ts_rate,
  output logic [7:0]       ts_ctrl,
  output logic [CNT_W-1:0] ts_consec,
  output logic             ts_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  rx_state_t  state;
  logic [3:0] idx;

  // Set under construction; only copied to the outputs once symbol 15 passes.
  logic [7:0] s_link, s_lane, s_nfts, s_rate, s_ctrl, s_id;
  logic       s_link_pad, s_lane_pad;

  logic is_com, is_pad, sym_ok, same_set;

  assign is_com = sym_k && (sym == COM);
  assign is_pad = sym_k && (sym == PADG12);

  always_comb begin
    sym_ok = 1'b0;
    if (idx == SYM_LINK || idx == SYM_LANE)
      sym_ok = !sym_k || is_pad;
    else if (idx >= SYM_NFTS && idx <= SYM_CTRL)
      sym_ok = !sym_k;
    else if (idx == SYM_ID0)
      sym_ok = !sym_k && (sym == TS1_ID || sym == TS2_ID);
    else if (idx > SYM_ID0)
      sym_ok = !sym_k && (sym == s_id);
  end

  // The identifier symbols all equal s_id by the time symbol 15 passes.
  assign same_set = (ts_consec != '0) &&
    ({(s_id == TS2_ID), s_link, s_link_pad, s_lane, s_lane_pad, s_nfts, s_rate, s_ctrl} ==
     {ts_is_ts2, ts_link, ts_link_pad, ts_lane, ts_lane_pad, ts_nfts, ts_rate, ts_ctrl});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RX_HUNT;
      idx         <= '0;
      s_link      <= '0;
      s_lane      <= '0;
      s_nfts      <= '0;
      s_rate      <= '0;
      s_ctrl      <= '0;
      s_id        <= '0;
      s_link_pad  <= 1'b0;
      s_lane_pad  <= 1'b0;
      ts_vld      <= 1'b0;
      ts_err      <= 1'b0;
      ts_is_ts2   <= 1'b0;
      ts_link     <= '0;
      ts_link_pad <= 1'b0;
      ts_lane     <= '0;
      ts_lane_pad <= 1'b0;
      ts_nfts     <= '0;
      ts_rate     <= '0;
      ts_ctrl     <= '0;
      ts_consec   <= '0;
    end else begin
      ts_vld <= 1'b0;
      ts_err <= 1'b0;
      if (sym_vld) begin
        case (state)
          RX_HUNT: begin
            if (is_com) begin
              state <= RX_COLLECT;
              idx   <= SYM_LINK;
            end
          end
          RX_COLLECT: begin
            if (is_com) begin
              // Abort the set in progress; this COM opens the next one.
              ts_err    <= 1'b1;
              ts_consec <= '0;
              idx       <= SYM_LINK;
            end else if (!sym_ok) begin
              ts_err    <= 1'b1;
              ts_consec <= '0;
              state     <= RX_HUNT;
              idx       <= '0;
            end else begin
              case (idx)
                SYM_LINK: begin s_link <= sym; s_link_pad <= is_pad; end
                SYM_LANE: begin s_lane <= sym; s_lane_pad <= is_pad; end
                SYM_NFTS: s_nfts <= sym;
                SYM_RATE: s_rate <= sym;
                SYM_CTRL: s_ctrl <= sym;
                SYM_ID0:  s_id   <= sym;
                default: ;
              endcase
              if (idx == SYM_LAST) begin
                ts_vld      <= 1'b1;
                ts_is_ts2   <= (s_id == TS2_ID);
                ts_link     <= s_link;
                ts_link_pad <= s_link_pad;
                ts_lane     <= s_lane;
                ts_lane_pad <= s_lane_pad;
                ts_nfts     <= s_nfts;
                ts_rate     <= s_rate;
                ts_ctrl     <= s_ctrl;
                if (!same_set)
                  ts_consec <= CNT_ONE;
                else if (ts_consec != CNT_MAX)
                  ts_consec <= ts_consec + CNT_ONE;
                state <= RX_HUNT;
                idx   <= '0;
              end else begin
                idx <= idx + 4'd1;
              end
            end
          end
          default: begin
            state <= RX_HUNT;
            idx   <= '0;
          end
        endcase
      end
    end
  end

endmodule
